// File: rtl/corr_sched_if.sv
// corr_sched_if: requester, correlator and response signals of the correlation scheduler
interface corr_sched_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid_i;
    logic             req0_ready_o;
    logic [WIDTH-1:0] req0_x_i;
    logic [WIDTH-1:0] req0_y_i;
    logic [4:0]       req0_len_i;
    logic             req1_valid_i;
    logic             req1_ready_o;
    logic [WIDTH-1:0] req1_x_i;
    logic [WIDTH-1:0] req1_y_i;
    logic [4:0]       req1_len_i;
    logic             corr_clr_o;
    logic             sig_x_o;
    logic             sig_y_o;
    logic             corr_z_i;
    logic             rsp_valid_o;
    logic             rsp_id_o;
    logic             rsp_balanced_o;
    logic             rsp_ready_i;

    modport slave (
        input  req0_valid_i, req0_x_i, req0_y_i, req0_len_i,
        input  req1_valid_i, req1_x_i, req1_y_i, req1_len_i,
        input  corr_z_i, rsp_ready_i,
        output req0_ready_o, req1_ready_o,
        output corr_clr_o, sig_x_o, sig_y_o,
        output rsp_valid_o, rsp_id_o, rsp_balanced_o
    );

    modport master (
        output req0_valid_i, req0_x_i, req0_y_i, req0_len_i,
        output req1_valid_i, req1_x_i, req1_y_i, req1_len_i,
        output corr_z_i, rsp_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  corr_clr_o, sig_x_o, sig_y_o,
        input  rsp_valid_o, rsp_id_o, rsp_balanced_o
    );
endinterface

// File: rtl/corr_sched.sv
// corr_sched: round-robin scheduler feeding serial correlation jobs to a shared correlator
module corr_sched #(
    parameter int WIDTH = 16
) (
    input logic         clk,
    input logic         reset,
    corr_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, SETTLE, RESP} state_t;

    localparam logic [4:0] WMAX = 5'(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] x_q, y_q;
    logic [4:0]       len_q, rem_q;
    logic             last_q;
    logic             clr_q, sx_q, sy_q;
    logic             rv_q, rid_q, rb_q;

    logic             idle, gnt0, gnt1;
    logic [WIDTH-1:0] sel_x_d, sel_y_d;
    logic [4:0]       sel_len, len_d;

    // Grant is combinational so the accept pulse lands in the same cycle the job is captured
    always_comb begin
        idle    = (state_q == IDLE) && !reset;
        gnt1    = idle && bus.req1_valid_i && (!bus.req0_valid_i || !last_q);
        gnt0    = idle && bus.req0_valid_i && !gnt1;
        sel_x_d = gnt1 ? bus.req1_x_i : bus.req0_x_i;
        sel_y_d = gnt1 ? bus.req1_y_i : bus.req0_y_i;
        sel_len = gnt1 ? bus.req1_len_i : bus.req0_len_i;
        len_d   = (sel_len > WMAX) ? WMAX : sel_len;
    end

    assign bus.req0_ready_o   = gnt0;
    assign bus.req1_ready_o   = gnt1;
    assign bus.corr_clr_o     = clr_q;
    assign bus.sig_x_o        = sx_q;
    assign bus.sig_y_o        = sy_q;
    assign bus.rsp_valid_o    = rv_q;
    assign bus.rsp_id_o       = rid_q;
    assign bus.rsp_balanced_o = rb_q;

    // Job sequencer: capture, clear, shift LSB first, settle, then hold the response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            last_q  <= 1'b1;
            clr_q   <= 1'b0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            rv_q    <= 1'b0;
            rid_q   <= 1'b0;
            rb_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        x_q     <= sel_x_d;
                        y_q     <= sel_y_d;
                        len_q   <= len_d;
                        rid_q   <= gnt1;
                        last_q  <= gnt1;
                        clr_q   <= 1'b1;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    clr_q <= 1'b0;
                    if (len_q == 5'd0) begin
                        state_q <= SETTLE;
                    end else begin
                        sx_q    <= x_q[0];
                        sy_q    <= y_q[0];
                        x_q     <= x_q >> 1;
                        y_q     <= y_q >> 1;
                        rem_q   <= len_q - 5'd1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rem_q == 5'd0) begin
                        sx_q    <= 1'b0;
                        sy_q    <= 1'b0;
                        state_q <= SETTLE;
                    end else begin
                        sx_q  <= x_q[0];
                        sy_q  <= y_q[0];
                        x_q   <= x_q >> 1;
                        y_q   <= y_q >> 1;
                        rem_q <= rem_q - 5'd1;
                    end
                end
                SETTLE: begin
                    rb_q    <= ~bus.corr_z_i;
                    rv_q    <= 1'b1;
                    state_q <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rv_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_corr_sched.sv
// tb_corr_sched: scoreboard bench with a correlator model and a job-level reference
module tb_corr_sched;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    corr_sched_if #(.WIDTH(W)) bus();
    corr_sched #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic id;
        logic bal;
        int   due;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   grant_cyc = -100;
    int   ngrants = 0;
    bit   last = 1'b1;
    bit   holding = 1'b0;
    int   cnt = 0;

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit balanced(logic [W-1:0] x, logic [W-1:0] y, logic [4:0] len);
        int l, cx, cy;
        l  = (int'(len) > W) ? W : int'(len);
        cx = 0;
        cy = 0;
        for (int i = 0; i < l; i++) begin
            cx += int'(x[i]);
            cy += int'(y[i]);
        end
        return cx == cy;
    endfunction

    // Correlator: running count of x ones minus y ones, cleared by the strobe
    always @(posedge clk) cnt <= bus.corr_clr_o ? 0 : cnt + int'(bus.sig_x_o) - int'(bus.sig_y_o);
    assign bus.corr_z_i = (cnt != 0);

    // Cycle counter for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: check grants against the arbitration rule and responses against the queue
    always @(negedge clk) begin : mon
        bit g0, g1, eg1, bal;
        int l;
        if (!reset) begin
            g0 = bus.req0_ready_o;
            g1 = bus.req1_ready_o;
            if (g0 || g1) begin
                chk("grant_single", int'(g0 && g1), 0);
                chk("grant_while_busy", q.size(), 0);
                chk("grant_without_valid", int'(g1 ? bus.req1_valid_i : bus.req0_valid_i), 1);
                eg1 = (bus.req0_valid_i && bus.req1_valid_i) ? !last : bus.req1_valid_i;
                chk("grant_id", int'(g1), int'(eg1));
                l   = int'(g1 ? bus.req1_len_i : bus.req0_len_i);
                l   = (l > W) ? W : l;
                bal = g1 ? balanced(bus.req1_x_i, bus.req1_y_i, bus.req1_len_i)
                         : balanced(bus.req0_x_i, bus.req0_y_i, bus.req0_len_i);
                q.push_back('{id: g1, bal: bal, due: cyc + l + 3});
                last = g1;
                grant_cyc = cyc;
                ngrants++;
            end else if ((bus.req0_valid_i || bus.req1_valid_i) && q.size() == 0) begin
                chk("grant_missing", 0, 1);
            end
            if (q.size() == 0) begin
                chk("idle_sig_x", int'(bus.sig_x_o), 0);
                chk("idle_sig_y", int'(bus.sig_y_o), 0);
            end
            if (bus.corr_clr_o) chk("clr_timing", cyc, grant_cyc + 1);
            if (bus.rsp_valid_o) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    if (!holding) chk("rsp_latency", cyc, q[0].due);
                    holding = 1'b1;
                    chk("rsp_id", int'(bus.rsp_id_o), int'(q[0].id));
                    chk("rsp_balanced", int'(bus.rsp_balanced_o), int'(q[0].bal));
                    if (bus.rsp_ready_i) begin
                        void'(q.pop_front());
                        holding = 1'b0;
                    end
                end
            end else if (holding) begin
                chk("rsp_dropped", 0, 1);
                holding = 1'b0;
            end
            if (q.size() > 0 && !holding && cyc > q[0].due) begin
                chk("rsp_missing", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    task automatic set_req(int r, bit v, logic [W-1:0] x, logic [W-1:0] y, logic [4:0] len);
        if (r == 0) begin
            bus.req0_valid_i = v;
            bus.req0_x_i     = x;
            bus.req0_y_i     = y;
            bus.req0_len_i   = len;
        end else begin
            bus.req1_valid_i = v;
            bus.req1_x_i     = x;
            bus.req1_y_i     = y;
            bus.req1_len_i   = len;
        end
    endtask

    task automatic wait_grant(int n);
        int start;
        bit ok;
        start = ngrants;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ngrants >= start + n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", 0, 1);
    endtask

    task automatic issue(int r, logic [W-1:0] x, logic [W-1:0] y, logic [4:0] len);
        set_req(r, 1'b1, x, y, len);
        wait_grant(1);
        @(posedge clk);
        #1;
        set_req(r, 1'b0, W'($urandom), W'($urandom), 5'($urandom));
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(string tag);
        chk({tag, "_req0_ready"}, int'(bus.req0_ready_o), 0);
        chk({tag, "_req1_ready"}, int'(bus.req1_ready_o), 0);
        chk({tag, "_clr"}, int'(bus.corr_clr_o), 0);
        chk({tag, "_sig_x"}, int'(bus.sig_x_o), 0);
        chk({tag, "_sig_y"}, int'(bus.sig_y_o), 0);
        chk({tag, "_rsp_valid"}, int'(bus.rsp_valid_o), 0);
        chk({tag, "_rsp_id"}, int'(bus.rsp_id_o), 0);
        chk({tag, "_rsp_bal"}, int'(bus.rsp_balanced_o), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        bus.rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        set_req(0, 1'b1, 16'h1234, 16'h4321, 5'd8);
        set_req(1, 1'b1, 16'h5678, 16'h8765, 5'd8);
        @(negedge clk);
        chk_outputs_zero("reset");
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue(0, 16'h00F0, 16'h0F00, 5'd16);
        drain();
        issue(1, 16'h0007, 16'h0001, 5'd4);
        drain();

        set_req(0, 1'b1, 16'h00FF, 16'h0F0F, 5'd8);
        set_req(1, 1'b1, 16'h0003, 16'h0001, 5'd2);
        wait_grant(4);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        drain();

        issue(0, 16'hA5A5, 16'h0001, 5'd0);
        drain();
        issue(1, 16'hFFFF, 16'h00FF, 5'd31);
        drain();
        issue(0, 16'h8001, 16'h0180, 5'd31);
        drain();

        bus.rsp_ready_i = 1'b0;
        issue(0, 16'h0013, 16'h0007, 5'd5);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("hold_rsp_timeout", 0, 1);
        @(posedge clk);
        #1;
        set_req(1, 1'b1, 16'h0F0F, 16'hF0F0, 5'd16);
        repeat (5) @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b1;
        wait_grant(1);
        @(posedge clk);
        #1;
        set_req(1, 1'b0, '0, '0, '0);
        drain();

        issue(1, 16'hFFFF, 16'h0000, 5'd16);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_outputs_zero("abort");
        q.delete();
        holding = 1'b0;
        last = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_req(0, 1'b1, 16'h0055, 16'h00AA, 5'd8);
        set_req(1, 1'b1, 16'h0001, 16'h0000, 5'd1);
        wait_grant(1);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        drain();

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            set_req(0, ($urandom % 3) == 0, W'($urandom), W'($urandom), 5'($urandom_range(0, 31)));
            set_req(1, ($urandom % 3) == 0, W'($urandom), W'($urandom), 5'($urandom_range(0, 31)));
            if (($urandom % 2) == 0) begin
                bus.req0_y_i = bus.req0_x_i ^ W'(16'h8001 << ($urandom % 8));
                bus.req1_y_i = {bus.req1_x_i[0], bus.req1_x_i[W-1:1]};
            end
            bus.rsp_ready_i = ($urandom % 3) != 0;
        end
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        bus.rsp_ready_i = 1'b1;
        drain();
        chk("final_queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
